// File: rtl/srq_pkg.sv
// Shared constants and types for the SRQ read-return path.
package srq_pkg;

  localparam int SRQ_WIDTH  = 1024;
  localparam int SRQ_BEAT_W = 64;

  typedef enum logic {
    SER_IDLE = 1'b0,
    SER_SEND = 1'b1
  } ser_state_e;

endpackage

// File: rtl/srq_beat_serializer.sv
// Pops one entry from the SRQ tail and streams it LSB beat first on a
// valid/ready interface, reloading on the last handshake so entries run back to back.
module srq_beat_serializer
  import srq_pkg::*;
#(
  parameter int  WIDTH  = SRQ_WIDTH,
  parameter int  BEAT_W = SRQ_BEAT_W,
  localparam int BEATS  = WIDTH / BEAT_W,
  localparam int CNT_W  = $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              srq_out_valid,
  input  logic [WIDTH-1:0]  srq_data,
  output logic              srq_pop,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BEAT_W-1:0] out_data,
  output logic              out_last,
  output logic [CNT_W-1:0]  out_beat,
  output logic              busy
);

  if ((WIDTH % BEAT_W) != 0 || (WIDTH / BEAT_W) < 2) begin : g_param_check
    $error("srq_beat_serializer: WIDTH must be a multiple of BEAT_W with at least two beats");
  end

  ser_state_e       state_r, state_s;
  logic [CNT_W-1:0] beat_cnt_r, beat_cnt_s;
  logic [WIDTH-1:0] data_buf_r;
  logic             load_s, shift_s, pop_s, hs_s, at_last_s;

  assign hs_s      = (state_r == SER_SEND) && out_ready;
  assign at_last_s = (beat_cnt_r == CNT_W'(BEATS - 1));

  // Next-state, beat counter and buffer control; flush overrides everything.
  always_comb begin
    state_s    = state_r;
    beat_cnt_s = beat_cnt_r;
    load_s     = 1'b0;
    shift_s    = 1'b0;
    pop_s      = 1'b0;
    if (flush) begin
      state_s    = SER_IDLE;
      beat_cnt_s = '0;
    end else begin
      case (state_r)
        SER_IDLE: begin
          if (srq_out_valid) begin
            pop_s      = 1'b1;
            load_s     = 1'b1;
            beat_cnt_s = '0;
            state_s    = SER_SEND;
          end else begin
            state_s = SER_IDLE;
          end
        end
        SER_SEND: begin
          if (!hs_s) begin
            state_s = SER_SEND;
          end else if (!at_last_s) begin
            shift_s    = 1'b1;
            beat_cnt_s = beat_cnt_r + CNT_W'(1);
          end else if (srq_out_valid) begin
            pop_s      = 1'b1;
            load_s     = 1'b1;
            beat_cnt_s = '0;
          end else begin
            state_s = SER_IDLE;
          end
        end
        default: begin
          state_s    = SER_IDLE;
          beat_cnt_s = '0;
        end
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= SER_IDLE;
      beat_cnt_r <= '0;
    end else begin
      state_r    <= state_s;
      beat_cnt_r <= beat_cnt_s;
    end
  end

  // Entry buffer, shifted right so the current beat always sits in the low bits.
  always_ff @(posedge clk) begin
    if (load_s) begin
      data_buf_r <= srq_data;
    end else if (shift_s) begin
      data_buf_r <= data_buf_r >> BEAT_W;
    end else begin
      data_buf_r <= data_buf_r;
    end
  end

  assign srq_pop   = pop_s && !rst;
  assign out_valid = (state_r == SER_SEND);
  assign busy      = (state_r == SER_SEND);
  assign out_last  = (state_r == SER_SEND) && at_last_s;
  assign out_beat  = beat_cnt_r;
  assign out_data  = data_buf_r[BEAT_W-1:0];

endmodule

// File: tb/tb_srq_beat_serializer.sv
// Self-checking bench for srq_beat_serializer: vector table, directed timing
// sequences and a randomized run against a queue-based reference model.
module tb_srq_beat_serializer;

  localparam int W  = 1024;
  localparam int BW = 64;
  localparam int NB = W / BW;

  logic          clk = 1'b0;
  logic          rst;
  logic          srq_out_valid;
  logic [W-1:0]  srq_data;
  logic          srq_pop;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;
  logic          out_last;
  logic [3:0]    out_beat;
  logic          busy;

  always #5 clk = ~clk;

  srq_beat_serializer dut (
    .clk(clk), .rst(rst), .srq_out_valid(srq_out_valid), .srq_data(srq_data),
    .srq_pop(srq_pop), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .out_beat(out_beat), .busy(busy)
  );

  int tests_run = 0;
  int fails     = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [BW-1:0] d; logic [3:0] i; } beat_t;
  beat_t        exp_q[$];
  logic [W-1:0] srq_q[$];
  bit           mon_en = 1'b0;
  bit           gate   = 1'b1;

  bit            hs_m, prev_stall;
  logic [BW-1:0] prev_data;
  logic [3:0]    prev_beat;

  task automatic drive_srq();
    srq_out_valid = (srq_q.size() > 0) && gate;
    srq_data      = (srq_q.size() > 0) ? srq_q[0] : '0;
  endtask

  function automatic logic [W-1:0] pattern_entry();
    logic [W-1:0] e;
    for (int i = 0; i < NB; i++) e[i*BW +: BW] = 64'hA5A5_0000_0000_0000 | 64'(i);
    return e;
  endfunction

  function automatic logic [W-1:0] rand_entry();
    logic [W-1:0] e;
    for (int i = 0; i < W / 32; i++) e[i*32 +: 32] = $urandom;
    return e;
  endfunction

  // An entry taken from the SRQ becomes NB expected beats; a flush discards what is left.
  always @(negedge clk) begin
    if (mon_en) begin
      hs_m = out_valid && out_ready;
      chk("valid_busy", {62'd0, out_valid, busy}, (exp_q.size() != 0) ? 64'd3 : 64'd0);
      chk("pop_empty", 64'(srq_pop && !srq_out_valid), 64'd0);
      if (prev_stall && out_valid) begin
        chk("stall_data", out_data, prev_data);
        chk("stall_beat", 64'(out_beat), 64'(prev_beat));
      end
      if (hs_m) begin
        chk("hs_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          chk("beat_data", out_data, exp_q[0].d);
          chk("beat_idx", 64'(out_beat), 64'(exp_q[0].i));
          chk("beat_last", 64'(out_last), 64'(exp_q[0].i == 4'(NB - 1)));
          void'(exp_q.pop_front());
        end
      end
      if (flush) exp_q.delete();
      if (srq_pop) begin
        chk("pop_early", 64'(exp_q.size()), 64'd0);
        if (srq_q.size() != 0) begin
          for (int i = 0; i < NB; i++) exp_q.push_back('{d: srq_q[0][i*BW +: BW], i: 4'(i)});
          void'(srq_q.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready && !flush;
      prev_data  = out_data;
      prev_beat  = out_beat;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic v, f, r;
    logic e_pop, e_valid;
    logic [3:0] e_beat;
    logic e_last;
  } vec_t;
  vec_t tbl[11];

  initial begin
    int pop_c, first_v, last_v, n_valid, n_last, last_c, pop2_c, n_pop, cyc;
    bit found;

    tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};

    // Reset state, with the SRQ claiming valid data to show pop is held off.
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; srq_out_valid = 1'b1; srq_data = '0;
    #12;
    chk("rst_pop", 64'(srq_pop), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_beat", 64'(out_beat), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; srq_out_valid = 1'b0;

    // Table: load, stall, flush with an entry waiting, reload from beat 0, flush again.
    srq_data = pattern_entry();
    for (int k = 0; k < 11; k++) begin
      srq_out_valid = tbl[k].v; flush = tbl[k].f; out_ready = tbl[k].r;
      @(negedge clk);
      chk($sformatf("tbl%0d_pop", k), 64'(srq_pop), 64'(tbl[k].e_pop));
      chk($sformatf("tbl%0d_valid", k), 64'(out_valid), 64'(tbl[k].e_valid));
      if (tbl[k].e_valid) begin
        chk($sformatf("tbl%0d_beat", k), 64'(out_beat), 64'(tbl[k].e_beat));
        chk($sformatf("tbl%0d_last", k), 64'(out_last), 64'(tbl[k].e_last));
        chk($sformatf("tbl%0d_data", k), out_data, 64'hA5A5_0000_0000_0000 | 64'(tbl[k].e_beat));
      end
      @(posedge clk); #1;
    end
    flush = 1'b0;

    // Single entry, ready held high: pop at 0, beats at 1..16, last only at 16.
    mon_en = 1'b1; gate = 1'b1; out_ready = 1'b1;
    srq_q.push_back(pattern_entry());
    pop_c = -1; first_v = -1; last_v = -1; n_valid = 0; n_last = 0; last_c = -1;
    for (int c = 0; c < 20; c++) begin
      drive_srq();
      @(negedge clk);
      if (srq_pop) pop_c = c;
      if (out_valid) begin
        n_valid++; last_v = c;
        if (first_v < 0) first_v = c;
        if (out_last) begin n_last++; last_c = c; end
      end
      @(posedge clk); #1;
    end
    chk("t1_pop_cycle", 64'(pop_c), 64'd0);
    chk("t1_first_beat", 64'(first_v), 64'd1);
    chk("t1_last_beat", 64'(last_v), 64'd16);
    chk("t1_n_valid", 64'(n_valid), 64'd16);
    chk("t1_last_cycle", 64'(last_c), 64'd16);
    chk("t1_n_last", 64'(n_last), 64'd1);

    // Two queued entries: 32 back-to-back beats, second pop on the first last beat.
    srq_q.push_back(rand_entry());
    srq_q.push_back(rand_entry());
    n_pop = 0; pop2_c = -1; last_c = -1; first_v = -1; last_v = -1; n_valid = 0;
    for (int c = 0; c < 40; c++) begin
      drive_srq();
      @(negedge clk);
      if (srq_pop) begin n_pop++; if (n_pop == 2) pop2_c = c; end
      if (out_valid) begin
        n_valid++; last_v = c;
        if (first_v < 0) first_v = c;
        if (out_last && last_c < 0) last_c = c;
      end
      @(posedge clk); #1;
    end
    chk("t2_n_pop", 64'(n_pop), 64'd2);
    chk("t2_n_valid", 64'(n_valid), 64'd32);
    chk("t2_no_bubble", 64'(last_v - first_v), 64'd31);
    chk("t2_pop_on_last", 64'(pop2_c), 64'(last_c));

    // Random ready, SRQ gaps and occasional flush against the model.
    for (int e = 0; e < 8; e++) srq_q.push_back(rand_entry());
    cyc = 0;
    while ((srq_q.size() != 0 || exp_q.size() != 0) && cyc < 3000) begin
      gate      = ($urandom_range(0, 3) != 0);
      out_ready = $urandom_range(0, 1);
      flush     = ($urandom_range(0, 39) == 0);
      drive_srq();
      @(negedge clk);
      @(posedge clk); #1;
      cyc++;
    end
    flush = 1'b0; gate = 1'b1; out_ready = 1'b1;
    chk("t3_drained", 64'(srq_q.size() + exp_q.size()), 64'd0);

    // Idle SRQ: nothing popped, nothing sent.
    srq_q.delete(); exp_q.delete();
    for (int c = 0; c < 100; c++) begin
      drive_srq();
      @(negedge clk);
      chk("t6_idle", {61'd0, srq_pop, out_valid, busy}, 64'd0);
      @(posedge clk); #1;
    end

    // Reset in the middle of an entry.
    srq_q.push_back(pattern_entry());
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      drive_srq();
      @(negedge clk);
      if (out_valid && out_beat == 4'd9) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("t5_reached_beat9", 64'(found), 64'd1);
    mon_en = 1'b0;
    #2;
    srq_out_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 64'(out_valid), 64'd0);
    chk("t5_rst_pop", 64'(srq_pop), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_beat", 64'(out_beat), 64'd0);
    srq_q.delete(); exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0; srq_out_valid = 1'b0;
    @(negedge clk);
    chk("t5_post_busy", 64'(busy), 64'd0);
    chk("t5_post_beat", 64'(out_beat), 64'd0);
    chk("t5_post_valid", 64'(out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
